// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small key-event FIFO; head entry is presented combinationally, zero when empty.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     CLK,
  input  logic     Resetn,
  input  logic     push,
  input  ps2_evt_t din,
  input  logic     pop,
  output ps2_evt_t dout,
  output logic     empty,
  output logic     full
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t       mem_reg [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           do_pop;
  logic           do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 device-to-host receiver: synchronizer, frame FSM with watchdog,
// E0/F0 prefix folding and a key-event FIFO with valid/ready drain.
module ps2_keyboard_ctrl
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       Resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       frame_err,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  // The error pulse is registered, so fire one count early to land it
  // exactly TIMEOUT_CYCLES after the cycle the last fall was seen.
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT_CYCLES - 2);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   prev_clk_reg;
  logic                   fall;
  logic                   bit_in;

  ps2_state_e             state_reg;
  logic [2:0]             bitcnt_reg;
  logic [7:0]             shreg_reg;
  logic                   byte_vld_reg;
  logic                   frame_err_reg;
  logic [WD_W-1:0]        wd_reg;

  logic                   ext_reg;
  logic                   brk_reg;
  logic                   push_req;
  ps2_evt_t               push_evt;
  ps2_evt_t               head_evt;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   overflow_reg;

  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
      prev_clk_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
      prev_clk_reg  <= clk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign fall   = prev_clk_reg && !clk_sync_reg[SYNC_STAGES-1];
  assign bit_in = data_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      state_reg     <= IDLE;
      bitcnt_reg    <= '0;
      shreg_reg     <= '0;
      byte_vld_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      wd_reg        <= '0;
    end else begin
      byte_vld_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      if (state_reg == IDLE || fall) wd_reg <= '0;
      else                           wd_reg <= wd_reg + WD_W'(1);

      case (state_reg)
        IDLE: begin
          if (fall && !bit_in) begin
            state_reg  <= DATA;
            bitcnt_reg <= '0;
          end
        end
        DATA: begin
          if (fall) begin
            shreg_reg  <= {bit_in, shreg_reg[7:1]};
            bitcnt_reg <= bitcnt_reg + 3'd1;
            if (bitcnt_reg == 3'd7) state_reg <= PARITY;
          end
        end
        PARITY: begin
          if (fall) begin
            if (^{shreg_reg, bit_in}) begin
              state_reg <= STOP;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= IDLE;
            end
          end
        end
        STOP: begin
          if (fall) begin
            if (bit_in) byte_vld_reg  <= 1'b1;
            else        frame_err_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (state_reg != IDLE && !fall && wd_reg == WD_FIRE) begin
        frame_err_reg <= 1'b1;
        state_reg     <= IDLE;
      end
    end
  end

  // shreg_reg holds the received byte while byte_vld_reg is high (FSM is idle).
  assign push_req = byte_vld_reg && (shreg_reg != PS2_EXT) && (shreg_reg != PS2_BRK);
  assign push_evt = '{ext: ext_reg, brk: brk_reg, code: shreg_reg};

  always_ff @(posedge CLK) begin
    if (!Resetn || frame_err_reg) begin
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end else if (byte_vld_reg) begin
      if (shreg_reg == PS2_EXT) begin
        ext_reg <= 1'b1;
      end else if (shreg_reg == PS2_BRK) begin
        brk_reg <= 1'b1;
      end else begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .Resetn (Resetn),
    .push   (push_req),
    .din    (push_evt),
    .pop    (evt_ready),
    .dout   (head_evt),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // A full FIFO is never empty, so a same-cycle pop is just evt_ready.
  always_ff @(posedge CLK) begin
    if (!Resetn)                                 overflow_reg <= 1'b0;
    else if (push_req && fifo_full && !evt_ready) overflow_reg <= 1'b1;
    else if (ovf_clr)                            overflow_reg <= 1'b0;
  end

  assign evt_valid = !fifo_empty;
  assign evt_code  = head_evt.code;
  assign evt_ext   = head_evt.ext;
  assign evt_break = head_evt.brk;
  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Directed plus randomized PS/2 frames checked against a byte-level reference model.
module tb_ps2_keyboard_ctrl;

  localparam int T     = 5000;
  localparam int HALF  = 8;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       Resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       frame_err;
  logic       overflow;

  ps2_keyboard_ctrl #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (T),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK       (CLK),
    .Resetn    (Resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .frame_err (frame_err),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Observation: frame_err pulses/timing, evt_valid rise time, popped events.
  int         err_pulses = 0;
  int         err_high   = 0;
  int         err_cyc    = -1;
  int         rise_cyc   = -1;
  logic       prev_err   = 1'b0;
  logic       prev_valid = 1'b0;
  logic [9:0] got_q[$];

  always @(negedge CLK) begin
    if (frame_err === 1'b1) begin
      err_high++;
      if (!prev_err) begin
        err_pulses++;
        err_cyc = cyc;
      end
    end
    prev_err = (frame_err === 1'b1);
    if (evt_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
    prev_valid = (evt_valid === 1'b1);
    if (evt_valid === 1'b1 && evt_ready) got_q.push_back({evt_ext, evt_break, evt_code});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: prefix flags and the sequence of events the consumer should see.
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [9:0] mdl_q[$];
  int         exp_err = 0;
  logic       exp_ovf = 1'b0;
  int         last_fall = 0;

  task automatic model_frame(input logic [7:0] b, input bit bad, input bit stalled);
    if (bad) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (stalled && mdl_q.size() >= DEPTH) exp_ovf = 1'b1;
      else mdl_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic compare_events(input string tag);
    chk({tag, "_count"}, got_q.size(), mdl_q.size());
    for (int i = 0; i < mdl_q.size() && i < got_q.size(); i++)
      chk({tag, "_evt"}, got_q[i], mdl_q[i]);
    $display("%s: %0d event(s) compared", tag, mdl_q.size());
    got_q.delete();
    mdl_q.delete();
  endtask

  task automatic ps2_edge(input logic b, input bit pop_at_push);
    @(posedge CLK); #1 ps2_data = b;
    repeat (HALF) @(posedge CLK);
    #1 ps2_clk = 1'b0;
    last_fall = cyc;
    if (pop_at_push) begin
      // Push lands in the cycle three edges after this drive.
      repeat (3) @(posedge CLK);
      #1 evt_ready = 1'b1;
      @(posedge CLK);
      #1 evt_ready = 1'b0;
      repeat (HALF - 4) @(posedge CLK);
    end else begin
      repeat (HALF) @(posedge CLK);
    end
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits,
                            input bit pop_at_push, input bit stalled);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_edge(bits[i], pop_at_push && i == 10);
    if (nbits == 11) model_frame(b, bad, stalled);
    repeat (HALF) @(posedge CLK);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_code"},  evt_code,  0);
    chk({tag, "_ext"},   evt_ext,   0);
    chk({tag, "_brk"},   evt_break, 0);
    chk({tag, "_ferr"},  frame_err, 0);
    chk({tag, "_ovf"},   overflow,  0);
  endtask

  initial begin
    logic [7:0] rb;
    bit         rbad;
    int         r;

    repeat (3) @(posedge CLK);
    #1 check_idle_outputs("reset");
    Resetn = 1'b1;
    repeat (4) @(posedge CLK);

    // 1: single make code, latency, held until ready
    send_frame(8'h1C, 0, 11, 0, 1);
    chk("t1_latency", rise_cyc, last_fall + 4);
    chk("t1_head", {evt_ext, evt_break, evt_code}, mdl_q[0]);
    chk("t1_no_err", err_pulses, 0);
    #1 evt_ready = 1'b1;
    repeat (3) @(posedge CLK);
    compare_events("t1");

    // 2: break prefix
    send_frame(8'hF0, 0, 11, 0, 0);
    compare_events("t2_f0");
    send_frame(8'h1C, 0, 11, 0, 0);
    compare_events("t2_1c");

    // 3: extended break, then plain make
    send_frame(8'hE0, 0, 11, 0, 0);
    send_frame(8'hF0, 0, 11, 0, 0);
    send_frame(8'h75, 0, 11, 0, 0);
    compare_events("t3_e0f075");
    send_frame(8'h75, 0, 11, 0, 0);
    compare_events("t3_75");

    // 4: parity errors, prefix cleared by error
    send_frame(8'h1C, 1, 11, 0, 0);
    compare_events("t4_bad");
    chk("t4_err_cnt", err_pulses, exp_err);
    send_frame(8'hE0, 0, 11, 0, 0);
    send_frame(8'h33, 1, 11, 0, 0);
    send_frame(8'h74, 0, 11, 0, 0);
    compare_events("t4_74");

    // Randomized byte stream, prefixes weighted in
    for (int n = 0; n < 24; n++) begin
      r    = $urandom_range(0, 9);
      rb   = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      rbad = ($urandom_range(0, 7) == 0);
      send_frame(rb, rbad, 11, 0, 0);
      compare_events("rand");
    end
    chk("rand_err_cnt", err_pulses, exp_err);
    chk("err_one_cycle", err_high, err_pulses);

    // 5: overflow with consumer stalled
    #1 evt_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send_frame(8'(k), 0, 11, 0, 1);
    chk("t5_valid", evt_valid, 1);
    chk("t5_head", {evt_ext, evt_break, evt_code}, mdl_q[0]);
    chk("t5_ovf", overflow, exp_ovf);
    @(posedge CLK); #1 ovf_clr = 1'b1;
    @(posedge CLK); #1 ovf_clr = 1'b0;
    chk("t5_ovf_clr", overflow, 0);
    evt_ready = 1'b1;
    repeat (6) @(posedge CLK);
    #1 compare_events("t5_drain");
    evt_ready = 1'b0;

    // Full FIFO with a same-cycle pop during the push
    for (int k = 8'h11; k <= 8'h14; k++) send_frame(8'(k), 0, 11, 0, 1);
    chk("t5_full_ovf0", overflow, 0);
    send_frame(8'h15, 0, 11, 1, 0);
    chk("t5_pp_ovf", overflow, 0);
    chk("t5_pp_head", {evt_ext, evt_break, evt_code}, mdl_q[1]);
    #1 evt_ready = 1'b1;
    repeat (6) @(posedge CLK);
    #1 compare_events("t5_pp_drain");

    // 6: watchdog timeout after 4 data bits, prefix dropped
    send_frame(8'hE0, 0, 11, 0, 0);
    send_frame(8'h5A, 0, 5, 0, 0);
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (T + 20) @(posedge CLK);
    chk("t6_timeout_cyc", err_cyc, last_fall + T + 2);
    chk("t6_err_cnt", err_pulses, exp_err);
    send_frame(8'h29, 0, 11, 0, 0);
    compare_events("t6_29");

    // Reset in the middle of a frame with an event pending
    #1 evt_ready = 1'b0;
    send_frame(8'h2A, 0, 11, 0, 1);
    send_frame(8'h3C, 0, 4, 0, 0);
    @(posedge CLK); #1 Resetn = 1'b0;
    repeat (2) @(posedge CLK);
    #1 check_idle_outputs("t6_rst");
    Resetn = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    mdl_q.delete();
    got_q.delete();
    repeat (T + 50) @(posedge CLK);
    chk("t6_rst_no_err", err_pulses, exp_err);
    chk("t6_rst_valid", evt_valid, 0);
    #1 evt_ready = 1'b1;
    send_frame(8'h29, 0, 11, 0, 0);
    compare_events("t6_post_rst");
    chk("final_one_cycle", err_high, err_pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
